instruction_fetch: RTL and testbench

Instruction fetch (IF) stage of the RISC-V pipeline. It owns the program counter and drives the address input of the combinational instruction memory. It captures the returned instruction word into the IF/ID pipeline register. It handles stall, flush, branch/jump redirect and halt-on-EBREAK, and sits between the instruction memory and the decode stage.

---
 rtl/instruction_fetch.sv | 135 +++++++++++++
 tb/tb_instruction_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RISC-V IF stage: PC, IF/ID register, stall/flush/redirect, halt on EBREAK.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic        misalign_fault
);
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] count_q, count_d;
    logic [31:0] redir_target;

    // The low two address bits are always dropped; the trap build only reports them.
    assign redir_target = redirect_pc & ~32'h3;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        count_d    = count_q;
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                id_pc_d    = 32'h0;
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
            end
            RUN: begin
                if (redirect_valid || flush) begin
                    id_pc_d    = 32'h0;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redir_target;
                    end
                end else if (!stall) begin
                    id_pc_d    = pc_q;
                    id_instr_d = imem_instr;
                    id_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end
                    if (imem_instr == EBREAK_INSTR) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid || !stall) begin
                    id_pc_d    = 32'h0;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                end
                if (redirect_valid) begin
                    pc_d    = redir_target;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'h0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            count_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            count_q    <= count_d;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_q;

    // Sticky: only reset clears it; redirects from BOOT are ignored along with the redirect itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect_valid && (state_q != BOOT) && (redirect_pc[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign misalign_fault = fault_q;
`else
    assign misalign_fault = 1'b0;
`endif

    assign imem_pc     = pc_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_instr = id_instr_q;
    assign if_id_valid = id_valid_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed table plus randomized reference-model check of instruction_fetch.
module tb_instruction_fetch;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] I0 = 32'h0010_0093;
    localparam logic [31:0] I1 = 32'h0020_0113;
    localparam logic [31:0] I2 = 32'h0020_81B3;
`ifdef IF_MISALIGN_TRAP_EN
    localparam logic FLT = 1'b1;
`else
    localparam logic FLT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, redirect_valid;
    logic [31:0] redirect_pc, imem_instr;
    logic [31:0] imem_pc, if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid, halted, misalign_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_count(fetch_count), .misalign_fault(misalign_fault)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'd0:   return I0;
            32'd4:   return I1;
            32'd8:   return I2;
            32'd12:  return EBREAK;
            default: return NOP;
        endcase
    endfunction

    always_comb imem_instr = mem_read(imem_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        rst_n = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, st, fl, rv;
        logic [31:0] rp;
        logic [31:0] e_pc, e_idpc, e_instr;
        logic        e_valid, e_halt;
        logic [31:0] e_cnt;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, st, fl, rv, input logic [31:0] rp,
                                input logic [31:0] pc, idpc, instr, input logic v, h,
                                input logic [31:0] cnt, input logic ft);
        vec_t x;
        x.rst = rst; x.st = st; x.fl = fl; x.rv = rv; x.rp = rp;
        x.e_pc = pc; x.e_idpc = idpc; x.e_instr = instr; x.e_valid = v; x.e_halt = h;
        x.e_cnt = cnt; x.e_fault = ft;
        return x;
    endfunction

    // Reference model state, updated once per rising edge from the spec's rules.
    logic        m_boot, m_halt, m_valid, m_fault;
    logic [31:0] m_pc, m_idpc, m_instr, m_cnt;

    task automatic m_bubble();
        m_idpc = 0; m_instr = NOP; m_valid = 0;
    endtask

    task automatic m_step(input logic r, s, f, rv, input logic [31:0] rp);
        logic [31:0] word;
        word = mem_read(m_pc);
        if (!r) begin
            m_boot = 1; m_halt = 0; m_pc = 0; m_cnt = 0; m_fault = 0; m_bubble();
        end else if (m_boot) begin
            m_boot = 0; m_bubble();
        end else if (rv) begin
            m_pc = {rp[31:2], 2'b00};
            m_bubble();
            m_halt = 0;
            if (FLT && rp[1:0] != 0) m_fault = 1;
        end else if (m_halt) begin
            if (!s) m_bubble();
        end else if (f) begin
            m_bubble();
        end else if (!s) begin
            m_idpc = m_pc; m_instr = word; m_valid = 1;
            m_pc = m_pc + 4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (word == EBREAK) m_halt = 1;
        end
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;

        //        rst st fl rv rp            pc            idpc          instr  v  h  cnt ft
        vecs.push_back(mk(0, 0, 0, 0, 0,            0,            0,            NOP,    0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h40,       0,            0,            NOP,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0,            0,            NOP,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            4,            0,            I0,     1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,            4,            0,            I0,     1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,            4,            0,            I0,     1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            8,            4,            I1,     1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0,            0,            0,            NOP,    0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            4,            0,            I0,     1, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            8,            4,            I1,     1, 0, 4, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            12,           8,            I2,     1, 0, 5, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            16,           12,           EBREAK, 1, 1, 6, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            16,           0,            NOP,    0, 1, 6, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            16,           0,            NOP,    0, 1, 6, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0,            0,            0,            NOP,    0, 0, 6, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            4,            0,            I0,     1, 0, 7, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0,            NOP,    0, 0, 7, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0,            32'hFFFFFFFC, NOP,    1, 0, 8, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h6,        4,            0,            NOP,    0, 0, 8, FLT));
        vecs.push_back(mk(1, 0, 0, 1, 32'hC,        12,           0,            NOP,    0, 0, 8, FLT));
        vecs.push_back(mk(1, 0, 0, 0, 0,            16,           12,           EBREAK, 1, 1, 9, FLT));
        vecs.push_back(mk(1, 1, 0, 0, 0,            16,           12,           EBREAK, 1, 1, 9, FLT));
        vecs.push_back(mk(1, 0, 0, 0, 0,            16,           0,            NOP,    0, 1, 9, FLT));
        vecs.push_back(mk(0, 1, 0, 0, 0,            0,            0,            NOP,    0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].rv, vecs[i].rp);
            chk($sformatf("v%0d imem_pc", i),     imem_pc,        vecs[i].e_pc);
            chk($sformatf("v%0d if_id_pc", i),    if_id_pc,       vecs[i].e_idpc);
            chk($sformatf("v%0d if_id_instr", i), if_id_instr,    vecs[i].e_instr);
            chk($sformatf("v%0d if_id_valid", i), {31'b0, if_id_valid},    {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d halted", i),      {31'b0, halted},         {31'b0, vecs[i].e_halt});
            chk($sformatf("v%0d fetch_count", i), fetch_count,    vecs[i].e_cnt);
            chk($sformatf("v%0d misalign", i),    {31'b0, misalign_fault}, {31'b0, vecs[i].e_fault});
        end

        // Randomized phase starting from a clean reset.
        m_step(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic r, s, f, rv;
            logic [31:0] rp;
            r  = ($urandom_range(99) >= 2);
            s  = ($urandom_range(99) < 25);
            f  = ($urandom_range(99) < 10);
            rv = ($urandom_range(99) < 12);
            rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                          : 32'($urandom_range(19));
            m_step(r, s, f, rv, rp);
            drive(r, s, f, rv, rp);
            chk("rnd imem_pc",     imem_pc,     m_pc);
            chk("rnd if_id_pc",    if_id_pc,    m_idpc);
            chk("rnd if_id_instr", if_id_instr, m_instr);
            chk("rnd if_id_valid", {31'b0, if_id_valid},    {31'b0, m_valid});
            chk("rnd halted",      {31'b0, halted},         {31'b0, m_halt});
            chk("rnd fetch_count", fetch_count, m_cnt);
            chk("rnd misalign",    {31'b0, misalign_fault}, {31'b0, m_fault});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
